// File: rtl/gauss_sep_nxn.sv
// Streaming separable binomial (Gaussian) low-pass filter, KSIZE x KSIZE.
// A horizontal binomial sum over the last KSIZE pixels feeds KSIZE-1 column-indexed
// line buffers. The vertical binomial sum over one column is rounded half-up to
// PIX_W bits. Outputs appear exactly 3 cycles after the pixel that completes
// the window.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pix_valid    input pixel qualifier
//   pix_in       input pixel, raster order
//   sof          start of frame (with pix_valid), marks pixel (0,0)
//   out_valid    one cycle per filtered pixel
//   out_pix      filtered pixel
//   out_row      row of the window centre
//   out_col      column of the window centre
//   frame_done   pulses with the last output of a complete frame
module gauss_sep_nxn #(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240,
    parameter int unsigned PIX_W        = 8,
    parameter int unsigned KSIZE        = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             sof,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pix,
    output logic [15:0]      out_row,
    output logic [15:0]      out_col,
    output logic             frame_done
);

    localparam int unsigned R      = (KSIZE - 1) / 2;
    localparam int unsigned S      = 2 * (KSIZE - 1);
    localparam int unsigned HSUM_W = PIX_W + KSIZE - 1;
    localparam int unsigned VSUM_W = PIX_W + S;
    localparam int unsigned NBUF   = KSIZE - 1;
    localparam int unsigned COL_W  = $clog2(IMAGE_WIDTH);
    localparam int unsigned ROW_W  = $clog2(IMAGE_HEIGHT);
    localparam logic [VSUM_W-1:0] HALF = VSUM_W'(1) << (S - 1);

    // Elaboration-time parameter legality.
    generate
        if (!(KSIZE == 3 || KSIZE == 5 || KSIZE == 7 || KSIZE == 9)) begin : g_bad_ksize
            $error("gauss_sep_nxn: KSIZE must be 3, 5, 7 or 9");
        end
        if (IMAGE_WIDTH < KSIZE || IMAGE_HEIGHT < KSIZE) begin : g_bad_size
            $error("gauss_sep_nxn: image must be at least KSIZE x KSIZE");
        end
    endgenerate

    // Binomial coefficient; only ever called with constant arguments.
    function automatic int unsigned binom(input int unsigned n, input int unsigned k);
        int unsigned c;
        c = 1;
        for (int unsigned i = 0; i < k; i++) begin
            c = c * (n - i) / (i + 1);
        end
        return c;
    endfunction

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             accept;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;

    // Frame position tracking: IDLE drops pixels until the next sof.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        accept  = 1'b0;
        cur_col = col_q;
        cur_row = row_q;
        if (pix_valid && (sof || state_q == ST_RUN)) begin
            accept  = 1'b1;
            state_d = ST_RUN;
            if (sof) begin
                cur_col = '0;
                cur_row = '0;
            end
            if (cur_col == COL_W'(IMAGE_WIDTH - 1)) begin
                col_d = '0;
                if (cur_row == ROW_W'(IMAGE_HEIGHT - 1)) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d = cur_row + ROW_W'(1);
                end
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Horizontal window, win[0] is the newest pixel.
    logic [PIX_W-1:0] win [KSIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(KSIZE); k++) begin
                win[k] <= '0;
            end
        end else if (accept) begin
            win[0] <= pix_in;
            for (int k = 1; k < int'(KSIZE); k++) begin
                win[k] <= win[k-1];
            end
        end
    end

    // Stage 1: control for the pixel whose window is now in win/tap.
    logic             s1_wr;
    logic             s1_out;
    logic             s1_last;
    logic [COL_W-1:0] s1_col;
    logic [15:0]      s1_orow;
    logic [15:0]      s1_ocol;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_wr   <= 1'b0;
            s1_out  <= 1'b0;
            s1_last <= 1'b0;
            s1_col  <= '0;
            s1_orow <= '0;
            s1_ocol <= '0;
        end else begin
            s1_wr   <= accept;
            s1_out  <= accept && (cur_row >= ROW_W'(2 * R)) && (cur_col >= COL_W'(2 * R));
            s1_last <= accept && (cur_row == ROW_W'(IMAGE_HEIGHT - 1))
                              && (cur_col == COL_W'(IMAGE_WIDTH - 1));
            if (accept) begin
                s1_col  <= cur_col;
                s1_orow <= 16'(cur_row) - 16'(R);
                s1_ocol <= 16'(cur_col) - 16'(R);
            end
        end
    end

    // Horizontal weighted sum over the window.
    logic [HSUM_W-1:0] hsum;

    always_comb begin
        hsum = '0;
        for (int k = 0; k < int'(KSIZE); k++) begin
            hsum = hsum + HSUM_W'(binom(KSIZE - 1, k)) * HSUM_W'(win[k]);
        end
    end

    // Line buffers: tap[j] holds the hsum from j+1 rows above, same column.
    // Read on accept, written back one cycle later shifted down by one buffer.
    // Contents are never cleared; rows before 2R are never emitted.
    logic [HSUM_W-1:0] lbuf [NBUF][IMAGE_WIDTH];
    logic [HSUM_W-1:0] tap  [NBUF];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < int'(NBUF); j++) begin
                tap[j] <= lbuf[j][cur_col];
            end
        end
        if (s1_wr) begin
            lbuf[0][s1_col] <= hsum;
            for (int j = 1; j < int'(NBUF); j++) begin
                lbuf[j][s1_col] <= tap[j-1];
            end
        end
    end

    // Vertical weighted sum over the column.
    logic [VSUM_W-1:0] vsum;

    always_comb begin
        vsum = VSUM_W'(binom(KSIZE - 1, 0)) * VSUM_W'(hsum);
        for (int j = 0; j < int'(NBUF); j++) begin
            vsum = vsum + VSUM_W'(binom(KSIZE - 1, j + 1)) * VSUM_W'(tap[j]);
        end
    end

    // Stage 2: full 2-D sum.
    logic              s2_out;
    logic              s2_last;
    logic [VSUM_W-1:0] s2_vsum;
    logic [15:0]       s2_orow;
    logic [15:0]       s2_ocol;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_out  <= 1'b0;
            s2_last <= 1'b0;
            s2_vsum <= '0;
            s2_orow <= '0;
            s2_ocol <= '0;
        end else begin
            s2_out  <= s1_out;
            s2_last <= s1_last;
            if (s1_out) begin
                s2_vsum <= vsum;
                s2_orow <= s1_orow;
                s2_ocol <= s1_ocol;
            end
        end
    end

    // Round half up; max vsum is (2^PIX_W-1)*2^S so the add cannot overflow.
    logic [VSUM_W-1:0] rounded;
    assign rounded = s2_vsum + HALF;

    // Stage 3: outputs, held while out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pix    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= s2_out;
            frame_done <= s2_out && s2_last;
            if (s2_out) begin
                out_pix <= PIX_W'(rounded >> S);
                out_row <= s2_orow;
                out_col <= s2_ocol;
            end
        end
    end

endmodule
